dds_freq_meter: RTL and testbench
=================================

Name: dds_freq_meter

Overview:
- Receive-side companion to the DDS: measures the frequency of a pulse/square stream (e.g. DDS sig_out MSB, or an external comparator output).
- Reports the equivalent DDS tuning word, so a loopback can check pa/pulse programming, or an external tone can be mapped to a tuning word.
- Gated edge counter: counts rising edges over a fixed window of 2^GATE_LOG2 clocks, then scales the count into tuning-word units.

Parameters:
- PA_WIDTH, 23, phase accumulator width of the matching DDS; sets the tuning-word scale.
- TUNE_WIDTH, 16, width of the reported tuning word.
- GATE_LOG2, 20, log2 of the gate window length in clk cycles. Legal range is 1..PA_WIDTH; elaboration fails outside it.

Ports:
- clk, input, 1, system clock (same domain as the DDS).
- RST, input, 1, synchronous active-high reset.
- sig_in, input, 1, signal under measurement.
- start, input, 1, request a measurement; sampled only in IDLE.
- busy, output, 1, high in GATE and DONE.
- meas_valid, output, 1, result available.
- meas_ready, input, 1, consumer accepts the result.
- tune_est, output, TUNE_WIDTH, estimated tuning word.
- edge_cnt, output, GATE_LOG2, raw rising-edge count of the last window.
- ovf, output, 1, tune_est saturated.

Behaviour:
- Reset: RST high at a clk edge forces the following.
  - State goes to IDLE.
  - busy=0, meas_valid=0, tune_est=0, edge_cnt=0, ovf=0.
  - Gate counter, edge counter and the sig_in history register all clear.
  - Reset mid-GATE or mid-DONE aborts the measurement and discards the result.
- Edge detect:
  - sig_prev is registered every cycle in all states.
  - A rising edge is sig_in==1 && sig_prev==0.
- IDLE:
  - start==1 moves to GATE on the next cycle.
  - On entry to GATE the gate counter and edge counter are 0.
- GATE:
  - Lasts exactly 2^GATE_LOG2 cycles.
  - Each cycle with a detected rising edge increments the edge counter, including the first and last GATE cycles.
  - After the last GATE cycle, go to DONE.
  - start is ignored while in GATE.
- Result computation:
  - Computed on the GATE→DONE transition and registered.
  - edge_cnt = final count.
  - tune_est = count << (PA_WIDTH-GATE_LOG2), evaluated at full width before truncation.
  - If the shifted value exceeds 2^TUNE_WIDTH-1: tune_est = all ones, ovf=1. Otherwise ovf=0.
- DONE:
  - meas_valid=1; tune_est, edge_cnt and ovf are held stable.
  - On meas_valid && meas_ready at a clk edge, go to IDLE; meas_valid=0 from the next cycle.
  - Outputs keep their last values in IDLE, but are only meaningful while meas_valid=1.
  - start is ignored in DONE.
  - If start is high in the cycle after the handshake (now in IDLE), a new measurement begins.
- Latency: start sampled in IDLE at cycle N gives meas_valid at cycle N+1+2^GATE_LOG2 (without the optional feature).
- Counter width: the maximum count is 2^(GATE_LOG2-1), which fits in GATE_LOG2 bits. The edge counter therefore never wraps and needs no saturation logic.
- Simultaneous events: RST has priority over start, the handshake, and gate expiry.

Optional Feature:
- Macro: DDS_FREQ_METER_SYNC_EN.
- Defined:
  - sig_in passes through a two-flop synchronizer before edge detect, for asynchronous external tones.
  - Synchronizer flops reset to 0.
  - Edges are counted delayed by 2 cycles; gate length and latency are unchanged.
  - An edge within the last 2 cycles before gate end is credited only if it reaches the detector inside the window.
- Undefined: sig_in feeds edge detect directly; sig_in must be synchronous to clk.

Test Plan:
- Defaults: sig_in square wave with period 256 clk, start pulse → edge_cnt=4096, tune_est=0x8000, ovf=0, meas_valid exactly 2^20+1 cycles after start.
- Defaults: period 1024 → edge_cnt=1024, tune_est=0x2000. Then period 128 → edge_cnt=8192, tune_est=0xFFFF, ovf=1.
- sig_in held constant at 1, then at 0 → edge_cnt=0, tune_est=0, ovf=0. No edge is counted for a level that is already high at entry to GATE.
- GATE_LOG2=4, sig_in toggling every cycle → edge_cnt=8 with an initial 0 history (rising edges on alternating cycles); meas_ready held low 10 cycles → outputs and meas_valid stable; start pulses during GATE/DONE have no effect.
- GATE_LOG2=4: RST pulse in mid-GATE → next cycle all outputs 0 and state IDLE; a fresh start then yields a correct full-window count.
- Loopback with dds, tuning_word=0x1000, PA_WIDTH=23, GATE_LOG2=20, sig_out MSB to sig_in → tune_est within ±8 of 0x1000; repeat with DDS_FREQ_METER_SYNC_EN defined, same tolerance.

Source files
------------

// File: rtl/dds_freq_meter.sv
// Gated rising-edge frequency meter reporting a DDS-equivalent tuning word.
// Define DDS_FREQ_METER_SYNC_EN to add a two-flop synchronizer on sig_in.
module dds_freq_meter #(
  parameter int PA_WIDTH   = 23,
  parameter int TUNE_WIDTH = 16,
  parameter int GATE_LOG2  = 20
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  sig_in,
  input  logic                  start,
  output logic                  busy,
  output logic                  meas_valid,
  input  logic                  meas_ready,
  output logic [TUNE_WIDTH-1:0] tune_est,
  output logic [GATE_LOG2-1:0]  edge_cnt,
  output logic                  ovf
);

  localparam int SHIFT = PA_WIDTH - GATE_LOG2;
  localparam int SW    = ((PA_WIDTH > TUNE_WIDTH) ? PA_WIDTH : TUNE_WIDTH) + 1;

  if (GATE_LOG2 < 1 || GATE_LOG2 > PA_WIDTH) begin : g_bad_gate_log2
    $error("dds_freq_meter: GATE_LOG2 must be in 1..PA_WIDTH");
  end

  typedef enum logic [1:0] {S_IDLE, S_GATE, S_DONE} state_e;

  state_e                state_q;
  logic                  sig_prev_q;
  logic [GATE_LOG2-1:0]  gate_cnt_q;
  logic [GATE_LOG2-1:0]  edge_acc_q;
  logic                  busy_q;
  logic                  valid_q;
  logic [TUNE_WIDTH-1:0] tune_q;
  logic [GATE_LOG2-1:0]  edge_cnt_q;
  logic                  ovf_q;

  logic                  sig_det;
  logic                  rise;
  logic [GATE_LOG2-1:0]  cnt_d;
  logic [SW-1:0]         scaled;
  logic                  sat_d;
  logic [TUNE_WIDTH-1:0] tune_d;

`ifdef DDS_FREQ_METER_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk) begin
    if (RST) sync_q <= '0;
    else     sync_q <= {sync_q[0], sig_in};
  end
  assign sig_det = sync_q[1];
`else
  assign sig_det = sig_in;
`endif

  // The final count includes an edge landing on the last gate cycle.
  assign rise   = sig_det & ~sig_prev_q;
  assign cnt_d  = edge_acc_q + GATE_LOG2'(rise);
  assign scaled = SW'(cnt_d) << SHIFT;
  assign sat_d  = |(scaled >> TUNE_WIDTH);
  assign tune_d = sat_d ? '1 : scaled[TUNE_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q    <= S_IDLE;
      sig_prev_q <= 1'b0;
      gate_cnt_q <= '0;
      edge_acc_q <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      tune_q     <= '0;
      edge_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      sig_prev_q <= sig_det;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_GATE;
            busy_q     <= 1'b1;
            gate_cnt_q <= '0;
            edge_acc_q <= '0;
          end
        end
        S_GATE: begin
          gate_cnt_q <= gate_cnt_q + 1'b1;
          edge_acc_q <= cnt_d;
          if (&gate_cnt_q) begin
            state_q    <= S_DONE;
            valid_q    <= 1'b1;
            tune_q     <= tune_d;
            edge_cnt_q <= cnt_d;
            ovf_q      <= sat_d;
          end
        end
        S_DONE: begin
          if (meas_ready) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign meas_valid = valid_q;
  assign tune_est   = tune_q;
  assign edge_cnt   = edge_cnt_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_dds_freq_meter.sv
// Directed bench for dds_freq_meter with a short 64-cycle gate (shift of 4 into an 8-bit word).
module tb_dds_freq_meter;
  localparam int PA = 10;
  localparam int TW = 8;
  localparam int GL = 6;
  localparam int GN = 1 << GL;

  logic          clk = 1'b0;
  logic          RST = 1'b1;
  logic          sig_in = 1'b0;
  logic          start = 1'b0;
  logic          meas_ready = 1'b0;
  logic          busy, meas_valid, ovf;
  logic [TW-1:0] tune_est;
  logic [GL-1:0] edge_cnt;

  int total = 0;
  int bad = 0;

  dds_freq_meter #(.PA_WIDTH(PA), .TUNE_WIDTH(TW), .GATE_LOG2(GL)) dut (
    .clk(clk), .RST(RST), .sig_in(sig_in), .start(start), .busy(busy),
    .meas_valid(meas_valid), .meas_ready(meas_ready), .tune_est(tune_est),
    .edge_cnt(edge_cnt), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Square-ish wave: high when (k+ph)%p is in the upper half, forced low from k>=lim.
  function automatic logic wave(input int p, input int ph, input int lim, input int k);
    return (k < lim) && (((k + ph) % p) >= (p / 2));
  endfunction

  // Pulses start, then drives one sig_in value per gate cycle; returns just after DONE entry.
  task automatic run_gate(input int p, input int ph, input int lim, input logic pre, input int inj_k);
    sig_in = pre;
    start  = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < GN; k++) begin
      sig_in = wave(p, ph, lim, k);
      start  = (k == inj_k);
      if (k == 0)      chk("busy_in_gate", 32'(busy), 32'd1);
      if (k == GN - 1) chk("valid_before_gate_end", 32'(meas_valid), 32'd0);
      tick;
    end
    start = 1'b0;
  endtask

  task automatic handshake;
    meas_ready = 1'b1;
    tick;
    meas_ready = 1'b0;
    chk("valid_after_ack", 32'(meas_valid), 32'd0);
    chk("busy_after_ack", 32'(busy), 32'd0);
  endtask

  typedef struct {
    int   p;
    int   ph;
    int   lim;
    logic pre;
    int   cnt;
    int   tune;
    logic ov;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{p: 16,  ph: 0, lim: 64, pre: 1'b0, cnt: 4,  tune: 'h40, ov: 1'b0};
    vecs[1]  = '{p: 8,   ph: 0, lim: 64, pre: 1'b0, cnt: 8,  tune: 'h80, ov: 1'b0};
    vecs[2]  = '{p: 32,  ph: 0, lim: 64, pre: 1'b0, cnt: 2,  tune: 'h20, ov: 1'b0};
    vecs[3]  = '{p: 4,   ph: 0, lim: 60, pre: 1'b0, cnt: 15, tune: 'hF0, ov: 1'b0};
    vecs[4]  = '{p: 4,   ph: 0, lim: 64, pre: 1'b0, cnt: 16, tune: 'hFF, ov: 1'b1};
    vecs[5]  = '{p: 2,   ph: 0, lim: 64, pre: 1'b0, cnt: 32, tune: 'hFF, ov: 1'b1};
    vecs[6]  = '{p: 2,   ph: 1, lim: 64, pre: 1'b0, cnt: 32, tune: 'hFF, ov: 1'b1};
    vecs[7]  = '{p: 1,   ph: 0, lim: 64, pre: 1'b1, cnt: 0,  tune: 'h00, ov: 1'b0};
    vecs[8]  = '{p: 1,   ph: 0, lim: 64, pre: 1'b0, cnt: 1,  tune: 'h10, ov: 1'b0};
    vecs[9]  = '{p: 1,   ph: 0, lim: 0,  pre: 1'b0, cnt: 0,  tune: 'h00, ov: 1'b0};
    vecs[10] = '{p: 128, ph: 1, lim: 64, pre: 1'b0, cnt: 1,  tune: 'h10, ov: 1'b0};

    repeat (3) tick;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(meas_valid), 32'd0);
    chk("rst_tune", 32'(tune_est), 32'd0);
    chk("rst_cnt", 32'(edge_cnt), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    RST = 1'b0;
    tick;

    for (int i = 0; i < 11; i++) begin
      run_gate(vecs[i].p, vecs[i].ph, vecs[i].lim, vecs[i].pre, -1);
      chk($sformatf("v%0d_valid", i), 32'(meas_valid), 32'd1);
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
      chk($sformatf("v%0d_cnt", i), 32'(edge_cnt), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_tune", i), 32'(tune_est), 32'(vecs[i].tune));
      chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].ov));
      handshake();
    end

    // Result held under back-pressure; start pulses in GATE and DONE must not disturb it.
    run_gate(16, 0, 64, 1'b0, 10);
    for (int j = 0; j < 10; j++) begin
      start  = (j % 3 == 0);
      sig_in = j[0];
      tick;
      chk("hold_valid", 32'(meas_valid), 32'd1);
      chk("hold_busy", 32'(busy), 32'd1);
      chk("hold_data", {22'd0, ovf, tune_est, edge_cnt}, {22'd0, 1'b0, 8'h40, 6'd4});
    end
    meas_ready = 1'b1;
    start      = 1'b1;
    tick;
    meas_ready = 1'b0;
    chk("ack_with_start_valid", 32'(meas_valid), 32'd0);
    chk("ack_with_start_busy", 32'(busy), 32'd0);
    tick;
    chk("restart_after_ack_busy", 32'(busy), 32'd1);
    start = 1'b0;

    // Abort that measurement mid-gate.
    for (int j = 0; j < 20; j++) begin
      sig_in = j[0];
      tick;
    end
    RST = 1'b1;
    tick;
    RST = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(meas_valid), 32'd0);
    chk("midrst_tune", 32'(tune_est), 32'd0);
    chk("midrst_cnt", 32'(edge_cnt), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    repeat (GN + 4) tick;
    chk("midrst_no_result", 32'(meas_valid), 32'd0);

    run_gate(8, 0, 64, 1'b0, -1);
    chk("post_rst_valid", 32'(meas_valid), 32'd1);
    chk("post_rst_cnt", 32'(edge_cnt), 32'd8);
    chk("post_rst_tune", 32'(tune_est), 32'h80);
    handshake();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
